spi_rx_pkt_ctrl: RTL and testbench

Read-side controller for the SPI-slave receive FIFO, running in the axi_aclk domain. It pops bytes from the FIFO and frames them into packets of the form SOF, LEN, payload, CSUM. It forwards payload bytes on a valid/ready stream and raises single-cycle start, end and error interrupts toward the PU. It also keeps saturating good-packet and bad-packet counters.

---
 rtl/spi_pkt_pkg.sv | 18 +
 rtl/sync_2ff.sv | 23 ++
 rtl/spi_rx_pkt_ctrl.sv | 136 +++++++++++++
 tb/tb_spi_rx_pkt_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkt_pkg.sv
// Shared types and constants for the SPI-slave receive packet controller.
package spi_pkt_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hA5;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAY,
    CSUM
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level; reset value selectable.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/spi_rx_pkt_ctrl.sv
// Pops the SPI RX FIFO, frames SOF/LEN/payload/CSUM packets, streams the payload
// and reports start/end/error events plus saturating good/bad packet counts.
module spi_rx_pkt_ctrl
  import spi_pkt_pkg::*;
#(
  parameter logic [7:0] SOF_BYTE       = SOF_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter int          CNT_W          = 16
) (
  input  logic             axi_aclk,
  input  logic             axi_areset,
  output logic             fifo_rd_en,
  input  logic [7:0]       fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             spi_cs_n,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             package_start_int,
  output logic             package_end_int,
  output logic             package_err_int,
  output logic [1:0]       err_code,
  output logic [7:0]       pkt_len,
  output logic [CNT_W-1:0] pkt_ok_cnt,
  output logic [CNT_W-1:0] pkt_err_cnt
);

  localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t            state;
  logic              cs_sync;
  logic              cs_prev;
  logic              cs_rise;
  logic              rd_pending;
  logic              capture;
  logic              timeout_hit;
  logic              abort_hit;
  logic [7:0]        csum;
  logic [7:0]        remaining;
  logic [IDLE_W-1:0] idle_cnt;

  sync_2ff #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk (axi_aclk),
    .rst (axi_areset),
    .d   (spi_cs_n),
    .q   (cs_sync)
  );

  // Data returns one cycle after the pop, so the pending flag doubles as the capture strobe.
  assign capture     = rd_pending;
  assign cs_rise     = cs_sync & ~cs_prev;
  assign abort_hit   = (state != HUNT) && cs_rise;
  assign timeout_hit = (state != HUNT) && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));
  assign fifo_rd_en  = !axi_areset && !fifo_empty && !rd_pending &&
                       ((state != PAY) || !out_valid);

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      state             <= HUNT;
      cs_prev           <= 1'b1;
      rd_pending        <= 1'b0;
      csum              <= '0;
      remaining         <= '0;
      idle_cnt          <= '0;
      out_data          <= '0;
      out_valid         <= 1'b0;
      out_last          <= 1'b0;
      package_start_int <= 1'b0;
      package_end_int   <= 1'b0;
      package_err_int   <= 1'b0;
      err_code          <= ERR_NONE;
      pkt_len           <= '0;
      pkt_ok_cnt        <= '0;
      pkt_err_cnt       <= '0;
    end else begin
      cs_prev           <= cs_sync;
      rd_pending        <= fifo_rd_en;
      package_start_int <= 1'b0;
      package_end_int   <= 1'b0;
      package_err_int   <= 1'b0;

      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end

      if (state == HUNT || capture || timeout_hit)
        idle_cnt <= '0;
      else
        idle_cnt <= idle_cnt + 1'b1;

      // A byte captured in the same cycle as an abort or timeout is dropped.
      if (abort_hit || timeout_hit) begin
        state           <= HUNT;
        package_err_int <= 1'b1;
        err_code        <= abort_hit ? ERR_ABORT : ERR_TIMEOUT;
        if (!(&pkt_err_cnt)) pkt_err_cnt <= pkt_err_cnt + 1'b1;
      end else if (capture) begin
        case (state)
          HUNT: begin
            if (fifo_rd_data == SOF_BYTE) state <= LEN;
          end
          LEN: begin
            pkt_len           <= fifo_rd_data;
            csum              <= fifo_rd_data;
            remaining         <= fifo_rd_data;
            package_start_int <= 1'b1;
            state             <= (fifo_rd_data == 8'd0) ? CSUM : PAY;
          end
          PAY: begin
            out_data  <= fifo_rd_data;
            out_valid <= 1'b1;
            out_last  <= (remaining == 8'd1);
            csum      <= csum ^ fifo_rd_data;
            remaining <= remaining - 8'd1;
            if (remaining == 8'd1) state <= CSUM;
          end
          CSUM: begin
            if (fifo_rd_data == csum) begin
              package_end_int <= 1'b1;
              if (!(&pkt_ok_cnt)) pkt_ok_cnt <= pkt_ok_cnt + 1'b1;
            end else begin
              package_err_int <= 1'b1;
              err_code        <= ERR_CSUM;
              if (!(&pkt_err_cnt)) pkt_err_cnt <= pkt_err_cnt + 1'b1;
            end
            state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_rx_pkt_ctrl.sv
// Directed bench for spi_rx_pkt_ctrl: FIFO model, stream monitor and pulse counters.
module tb_spi_rx_pkt_ctrl;

  localparam int CNT_W = 16;

  logic             axi_aclk = 1'b0;
  logic             axi_areset = 1'b1;
  logic             fifo_rd_en;
  logic [7:0]       fifo_rd_data = 8'h00;
  logic             fifo_empty = 1'b1;
  logic             spi_cs_n = 1'b0;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready = 1'b1;
  logic             package_start_int;
  logic             package_end_int;
  logic             package_err_int;
  logic [1:0]       err_code;
  logic [7:0]       pkt_len;
  logic [CNT_W-1:0] pkt_ok_cnt;
  logic [CNT_W-1:0] pkt_err_cnt;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] fifo_q[$];
  logic [7:0] rx_data[256];
  logic       rx_last[256];
  int         rx_n = 0;
  int         start_n = 0;
  int         end_n = 0;
  int         err_n = 0;

  spi_rx_pkt_ctrl #(
    .SOF_BYTE       (8'hA5),
    .TIMEOUT_CYCLES (16),
    .CNT_W          (CNT_W)
  ) dut (
    .axi_aclk          (axi_aclk),
    .axi_areset        (axi_areset),
    .fifo_rd_en        (fifo_rd_en),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_empty        (fifo_empty),
    .spi_cs_n          (spi_cs_n),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_last          (out_last),
    .out_ready         (out_ready),
    .package_start_int (package_start_int),
    .package_end_int   (package_end_int),
    .package_err_int   (package_err_int),
    .err_code          (err_code),
    .pkt_len           (pkt_len),
    .pkt_ok_cnt        (pkt_ok_cnt),
    .pkt_err_cnt       (pkt_err_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  // FIFO with one-cycle read latency.
  always @(posedge axi_aclk) begin
    if (fifo_rd_en && fifo_q.size() > 0) begin
      fifo_rd_data <= fifo_q.pop_front();
      fifo_empty   <= (fifo_q.size() == 0);
    end
  end

  always @(posedge axi_aclk) begin
    if (!axi_areset) begin
      if (out_valid && out_ready && rx_n < 256) begin
        rx_data[rx_n] = out_data;
        rx_last[rx_n] = out_last;
        rx_n++;
      end
      if (package_start_int) start_n++;
      if (package_end_int)   end_n++;
      if (package_err_int)   err_n++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge axi_aclk);
  endtask

  task automatic apply_stimulus(input logic [7:0] bytes[$]);
    foreach (bytes[i]) fifo_q.push_back(bytes[i]);
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rx0, st0, en0, er0, k;
    logic [7:0] held_ok;
    logic       rd_seen;

    tick(3);
    check_output("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("reset_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check_output("reset_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd0);
    check_output("reset_err_code", {30'd0, err_code}, 32'd0);
    axi_areset = 1'b0;
    tick(2);

    $display("[TB] good packet");
    rx0 = rx_n; st0 = start_n; en0 = end_n; er0 = err_n;
    apply_stimulus('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
    tick(30);
    check_output("good_rx_count", rx_n - rx0, 3);
    check_output("good_byte0", {24'd0, rx_data[rx0]}, 32'h11);
    check_output("good_byte1", {24'd0, rx_data[rx0+1]}, 32'h22);
    check_output("good_byte2", {24'd0, rx_data[rx0+2]}, 32'h33);
    check_output("good_last_flags", {29'd0, rx_last[rx0+2], rx_last[rx0+1], rx_last[rx0]}, 32'b100);
    check_output("good_start", start_n - st0, 1);
    check_output("good_end", end_n - en0, 1);
    check_output("good_err", err_n - er0, 0);
    check_output("good_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd1);
    check_output("good_pkt_len", {24'd0, pkt_len}, 32'd3);

    $display("[TB] bad checksum");
    rx0 = rx_n; en0 = end_n; er0 = err_n;
    apply_stimulus('{8'hA5, 8'h02, 8'h01, 8'h02, 8'hFF});
    tick(30);
    check_output("bad_rx_count", rx_n - rx0, 2);
    check_output("bad_bytes", {16'd0, rx_data[rx0], rx_data[rx0+1]}, 32'h0102);
    check_output("bad_err", err_n - er0, 1);
    check_output("bad_end", end_n - en0, 0);
    check_output("bad_err_code", {30'd0, err_code}, 32'd1);
    check_output("bad_err_cnt", {16'd0, pkt_err_cnt}, 32'd1);

    $display("[TB] zero length with leading garbage");
    rx0 = rx_n; st0 = start_n; en0 = end_n;
    apply_stimulus('{8'h00, 8'h7F, 8'hA5, 8'h00, 8'h00});
    tick(30);
    check_output("zero_rx_count", rx_n - rx0, 0);
    check_output("zero_start", start_n - st0, 1);
    check_output("zero_end", end_n - en0, 1);
    check_output("zero_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd2);
    check_output("zero_pkt_len", {24'd0, pkt_len}, 32'd0);

    $display("[TB] backpressure");
    rx0 = rx_n; en0 = end_n;
    out_ready = 1'b0;
    apply_stimulus('{8'hA5, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40, 8'h44});
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin tick(1); k++; end
    check_output("bp_valid_seen", {31'd0, out_valid}, 32'd1);
    held_ok = 8'h01;
    rd_seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (out_data !== 8'h10 || out_valid !== 1'b1) held_ok = 8'h00;
      if (fifo_rd_en !== 1'b0) rd_seen = 1'b1;
      tick(1);
    end
    check_output("bp_data_stable", {24'd0, held_ok}, 32'd1);
    check_output("bp_no_pop", {31'd0, rd_seen}, 32'd0);
    out_ready = 1'b1;
    tick(30);
    check_output("bp_rx_count", rx_n - rx0, 4);
    check_output("bp_bytes", {rx_data[rx0], rx_data[rx0+1], rx_data[rx0+2], rx_data[rx0+3]}, 32'h10203040);
    check_output("bp_last", {31'd0, rx_last[rx0+3]}, 32'd1);
    check_output("bp_end", end_n - en0, 1);
    check_output("bp_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd3);

    $display("[TB] timeout");
    rx0 = rx_n;
    apply_stimulus('{8'hA5, 8'h05, 8'hAA});
    k = 0;
    while (out_valid !== 1'b1 && k < 20) begin tick(1); k++; end
    check_output("to_first_byte", {24'd0, out_data}, 32'hAA);
    k = 0;
    while (package_err_int !== 1'b1 && k < 40) begin tick(1); k++; end
    check_output("to_latency", k, 16);
    check_output("to_err_code", {30'd0, err_code}, 32'd2);
    check_output("to_err_cnt", {16'd0, pkt_err_cnt}, 32'd2);
    rx0 = rx_n;
    apply_stimulus('{8'hA5, 8'h01, 8'h5A, 8'h5B});
    tick(30);
    check_output("to_next_byte", {23'd0, rx_last[rx0], rx_data[rx0]}, 32'h15A);
    check_output("to_next_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd4);

    $display("[TB] cs abort");
    apply_stimulus('{8'hA5, 8'h03, 8'h01});
    tick(12);
    spi_cs_n = 1'b1;
    k = 0;
    while (package_err_int !== 1'b1 && k < 6) begin tick(1); k++; end
    check_output("abort_latency_ok", {31'd0, (k >= 2 && k <= 4)}, 32'd1);
    check_output("abort_err_code", {30'd0, err_code}, 32'd3);
    check_output("abort_err_cnt", {16'd0, pkt_err_cnt}, 32'd3);
    check_output("abort_pkt_len", {24'd0, pkt_len}, 32'd3);
    spi_cs_n = 1'b0;
    tick(5);

    $display("[TB] reset mid-packet");
    apply_stimulus('{8'hA5, 8'h02, 8'h07});
    tick(8);
    axi_areset = 1'b1;
    tick(1);
    axi_areset = 1'b0;
    check_output("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_output("rst_out_data", {24'd0, out_data}, 32'd0);
    check_output("rst_pkt_len", {24'd0, pkt_len}, 32'd0);
    check_output("rst_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd0);
    check_output("rst_err_cnt", {16'd0, pkt_err_cnt}, 32'd0);
    check_output("rst_err_code", {30'd0, err_code}, 32'd0);
    check_output("rst_pulses", {29'd0, package_start_int, package_end_int, package_err_int}, 32'd0);
    st0 = start_n; en0 = end_n;
    apply_stimulus('{8'h02, 8'h07, 8'hA5, 8'h00, 8'h00});
    tick(30);
    check_output("post_rst_start", start_n - st0, 1);
    check_output("post_rst_end", end_n - en0, 1);
    check_output("post_rst_ok_cnt", {16'd0, pkt_ok_cnt}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
